// File: rtl/simd_sat_addsub_pkg.sv
// Shared op encoding, per-beat control word and saturation bound helpers
// for the packed-SIMD saturating add/sub datapath.
package simd_alu_pkg;

  typedef enum logic [1:0] {
    OP_SADD = 2'b00,
    OP_SSUB = 2'b01,
    OP_UADD = 2'b10,
    OP_USUB = 2'b11
  } simd_op_e;

  typedef struct packed {
    simd_op_e op;
    logic     sat_en;
  } simd_ctl_t;

  function automatic logic [63:0] sat_max_s(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_s(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic logic [63:0] sat_max_u(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/simd_sat_addsub_if.sv
// Operand and result valid/ready channels of the SIMD add/sub unit.
// master drives operands and consumes results; slave is the unit itself.
interface simd_sat_addsub_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
);
  localparam int DW = LANE_W * LANES;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [1:0]       in_op;
  logic             in_sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_sum;
  logic [LANES-1:0] out_ovf;
  logic             out_error;

  modport master (
    output in_valid, in_a, in_b, in_op, in_sat_en, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_error
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_sat_en, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_error
  );

endinterface

// File: rtl/simd_sat_addsub_lane.sv
// One SIMD lane: raw add/sub + overflow flag (stage 1), saturate-or-wrap select (stage 2).
// Purely combinational; the two halves are fed from different pipeline stages.
module simd_sat_lane
  import simd_alu_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  simd_op_e          op,
  output logic [LANE_W:0]   raw,
  output logic              ovf,
  input  logic [LANE_W:0]   sel_raw,
  input  logic              sel_ovf,
  input  simd_ctl_t         sel_ctl,
  output logic [LANE_W-1:0] res
);

  localparam logic [63:0] MAX_S64 = sat_max_s(LANE_W);
  localparam logic [63:0] MIN_S64 = sat_min_s(LANE_W);
  localparam logic [63:0] MAX_U64 = sat_max_u(LANE_W);
  localparam logic [LANE_W-1:0] MAX_S = MAX_S64[LANE_W-1:0];
  localparam logic [LANE_W-1:0] MIN_S = MIN_S64[LANE_W-1:0];
  localparam logic [LANE_W-1:0] MAX_U = MAX_U64[LANE_W-1:0];

  logic sat_hit;

  always_comb begin
    raw = '0;
    ovf = 1'b0;
    if (op == OP_SADD || op == OP_UADD) raw = {1'b0, a} + {1'b0, b};
    else                                raw = {1'b0, a} - {1'b0, b};
    case (op)
      OP_SADD: ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
      OP_SSUB: ovf = (a[LANE_W-1] != b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
      default: ovf = raw[LANE_W];  // carry-out on add, borrow on sub
    endcase
  end

  // A signed overflow always flips the result sign away from A, so a negative
  // raw result means A was non-negative and the lane clamps to the maximum.
  always_comb begin
    sat_hit = (sel_ctl.op == OP_UADD || sel_ctl.op == OP_USUB) ? sel_raw[LANE_W] : sel_ovf;
    res     = sel_raw[LANE_W-1:0];
    if (sel_ctl.sat_en && sat_hit) begin
      case (sel_ctl.op)
        OP_SADD, OP_SSUB: res = sel_raw[LANE_W-1] ? MAX_S : MIN_S;
        OP_UADD:          res = MAX_U;
        default:          res = '0;
      endcase
    end
  end

endmodule

// File: rtl/simd_sat_addsub.sv
// Packed-SIMD saturating/wrapping add-sub with sticky per-lane overflow status.
// Latency 2 clk, 1 beat/clk; in_ready follows out_ready combinationally, no skid buffer.
module simd_sat_addsub
  import simd_alu_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  simd_sat_addsub_if.slave bus,
  input  logic             clr_sticky,
  output logic [LANES-1:0] sticky_ovf
);

  logic      s1_vld;
  logic      adv1;
  logic      adv2;
  logic      out_hs;
  simd_ctl_t in_ctl;
  simd_ctl_t s1_ctl;

  logic [LANES-1:0][LANE_W:0]   raw_c;
  logic [LANES-1:0][LANE_W:0]   s1_raw;
  logic [LANES-1:0]             ovf_c;
  logic [LANES-1:0]             s1_ovf;
  logic [LANES-1:0][LANE_W-1:0] res_c;

  assign adv2          = !bus.out_valid || bus.out_ready;
  assign adv1          = !s1_vld || adv2;
  assign bus.in_ready  = adv1;
  assign out_hs        = bus.out_valid && bus.out_ready;
  assign bus.out_error = |bus.out_ovf;
  assign in_ctl        = '{op: simd_op_e'(bus.in_op), sat_en: bus.in_sat_en};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_sat_lane #(.LANE_W(LANE_W)) u_lane (
      .a       (bus.in_a[i*LANE_W +: LANE_W]),
      .b       (bus.in_b[i*LANE_W +: LANE_W]),
      .op      (in_ctl.op),
      .raw     (raw_c[i]),
      .ovf     (ovf_c[i]),
      .sel_raw (s1_raw[i]),
      .sel_ovf (s1_ovf[i]),
      .sel_ctl (s1_ctl),
      .res     (res_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_raw <= '0;
      s1_ovf <= '0;
      s1_ctl <= '0;
    end else if (adv1) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_raw <= raw_c;
        s1_ovf <= ovf_c;
        s1_ctl <= in_ctl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= '0;
    end else if (adv2) begin
      bus.out_valid <= s1_vld;
      if (s1_vld) begin
        bus.out_sum <= res_c;
        bus.out_ovf <= s1_ovf;
      end
    end
  end

  // A clear coinciding with a handshake keeps that beat's flags.
  always_ff @(posedge clk) begin
    if (rst)             sticky_ovf <= '0;
    else if (out_hs)     sticky_ovf <= clr_sticky ? bus.out_ovf : (sticky_ovf | bus.out_ovf);
    else if (clr_sticky) sticky_ovf <= '0;
  end

endmodule

// File: tb/tb_simd_sat_addsub.sv
// Bench for simd_sat_addsub: directed 4x4 vector table, backpressure, sticky and
// reset sequences, randomised traffic against an integer model, and an 8x8 instance.
module tb_simd_sat_addsub;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        sat;
    logic [15:0] sum;
    logic [3:0]  ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr4;
  logic       clr8;
  logic [3:0] sticky4;
  logic [7:0] sticky8;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  simd_sat_addsub_if #(.LANE_W(4), .LANES(4)) bus4 ();
  simd_sat_addsub_if #(.LANE_W(8), .LANES(8)) bus8 ();

  simd_sat_addsub #(.LANE_W(4), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .clr_sticky(clr4), .sticky_ovf(sticky4)
  );
  simd_sat_addsub #(.LANE_W(8), .LANES(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .clr_sticky(clr8), .sticky_ovf(sticky8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact integer arithmetic, then range test and clamp.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] op, input logic sat,
                                input int w, input int n,
                                output logic [63:0] sum, output logic [7:0] ovf);
    int ua, ub, sa, sb, r, lo, hi, m;
    sum = '0;
    ovf = '0;
    m   = (1 << w) - 1;
    for (int i = 0; i < n; i++) begin
      ua = int'((a >> (i*w)) & 64'(m));
      ub = int'((b >> (i*w)) & 64'(m));
      sa = (ua > m/2) ? ua - (m + 1) : ua;
      sb = (ub > m/2) ? ub - (m + 1) : ub;
      if (!op[1]) begin
        lo = -(m + 1) / 2;
        hi = m / 2;
        r  = op[0] ? sa - sb : sa + sb;
      end else begin
        lo = 0;
        hi = m;
        r  = op[0] ? ua - ub : ua + ub;
      end
      ovf[i] = (r < lo) || (r > hi);
      if (sat && ovf[i]) r = (r > hi) ? hi : lo;
      sum |= 64'(r & m) << (i*w);
    end
  endfunction

  // Single beat with out_ready high; checks exact 2-stage timing.
  task automatic run_vec(input vec_t v);
    bus4.in_a = v.a; bus4.in_b = v.b; bus4.in_op = v.op; bus4.in_sat_en = v.sat;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    #1;
    chk({v.name, "/in_ready"}, bus4.in_ready, 1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.in_op = ~v.op;        // must not affect the beat already accepted
    bus4.in_sat_en = ~v.sat;
    chk({v.name, "/valid_early"}, bus4.out_valid, 0);
    @(posedge clk); #1;
    chk({v.name, "/valid"}, bus4.out_valid, 1);
    chk({v.name, "/sum"}, bus4.out_sum, v.sum);
    chk({v.name, "/ovf"}, bus4.out_ovf, v.ovf);
    chk({v.name, "/error"}, bus4.out_error, |v.ovf);
  endtask

  task automatic run8(input string name, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] op, input logic sat,
                      input logic [63:0] esum, input logic [7:0] eovf);
    bus8.in_a = a; bus8.in_b = b; bus8.in_op = op; bus8.in_sat_en = sat;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "/valid"}, bus8.out_valid, 1);
    chk({name, "/sum"}, bus8.out_sum, esum);
    chk({name, "/ovf"}, bus8.out_ovf, eovf);
  endtask

  vec_t        tbl[13];
  vec_t        v_uadd1, v_sadd_l1;
  logic [63:0] exp_sum_q[$];
  logic [7:0]  exp_ovf_q[$];
  logic [63:0] ms, held_sum;
  logic [7:0]  mo;
  logic [3:0]  sticky_exp;
  logic        prev_stall, saw_full, in_hs;
  int          got, idx;

  initial begin
    tbl[0]  = '{"sadd_sat",   16'h7381, 16'h12F1, 2'b00, 1'b1, 16'h7582, 4'b1010};
    tbl[1]  = '{"sadd_wrap",  16'h7381, 16'h12F1, 2'b00, 1'b0, 16'h8572, 4'b1010};
    tbl[2]  = '{"ssub_sat",   16'h8700, 16'h1F18, 2'b01, 1'b1, 16'h87F7, 4'b1101};
    tbl[3]  = '{"ssub_wrap",  16'h8700, 16'h1F18, 2'b01, 1'b0, 16'h78F8, 4'b1101};
    tbl[4]  = '{"uadd_sat",   16'hF0A8, 16'h1F68, 2'b10, 1'b1, 16'hFFFF, 4'b1011};
    tbl[5]  = '{"uadd_wrap",  16'hF0A8, 16'h1F68, 2'b10, 1'b0, 16'h0F00, 4'b1011};
    tbl[6]  = '{"usub_sat",   16'h0123, 16'h1111, 2'b11, 1'b1, 16'h0012, 4'b1000};
    tbl[7]  = '{"usub_wrap",  16'h0123, 16'h1111, 2'b11, 1'b0, 16'hF012, 4'b1000};
    tbl[8]  = '{"sadd_clean", 16'h1234, 16'h2143, 2'b00, 1'b1, 16'h3377, 4'b0000};
    tbl[9]  = '{"ssub_min",   16'h8008, 16'h0001, 2'b01, 1'b1, 16'h8008, 4'b0001};
    tbl[10] = '{"usub_equal", 16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 4'b0000};
    tbl[11] = '{"uadd_edge",  16'h8F7F, 16'h7011, 2'b10, 1'b1, 16'hFF8F, 4'b0001};
    tbl[12] = '{"ssub_max",   16'h7000, 16'h8000, 2'b01, 1'b1, 16'h7000, 4'b1000};
    v_uadd1   = '{"uadd_small", 16'h0001, 16'h0001, 2'b10, 1'b1, 16'h0002, 4'b0000};
    v_sadd_l1 = '{"sadd_lane1", 16'h0080, 16'h0080, 2'b00, 1'b1, 16'h0080, 4'b0010};

    rst = 1'b1; clr4 = 1'b0; clr8 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_op = '0;
    bus4.in_sat_en = 1'b0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_op = '0;
    bus8.in_sat_en = 1'b0; bus8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/out_valid", bus4.out_valid, 0);
    chk("reset/out_sum", bus4.out_sum, 0);
    chk("reset/out_ovf", bus4.out_ovf, 0);
    chk("reset/out_error", bus4.out_error, 0);
    chk("reset/sticky", sticky4, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);
    @(posedge clk); #1;

    // Sticky accumulation and clearing
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    chk("sticky/clear", sticky4, 0);
    run_vec(tbl[6]);
    run_vec(v_uadd1);
    @(posedge clk); #1;
    chk("sticky/accum", sticky4, 4'b1000);
    run_vec(v_sadd_l1);
    clr4 = 1'b1;               // clear in the same cycle as this beat's handshake
    @(posedge clk); #1;
    clr4 = 1'b0;
    chk("sticky/clr_with_hs", sticky4, 4'b0010);
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    chk("sticky/clr_idle", sticky4, 0);

    // Backpressure: three beats, consumer stalled long enough to fill both stages
    idx = 0; got = 0; saw_full = 1'b0; prev_stall = 1'b0; held_sum = '0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      bus4.out_ready = (cyc >= 6);
      bus4.in_valid  = (idx < 3);
      if (idx < 3) begin
        bus4.in_a = tbl[idx*2].a; bus4.in_b = tbl[idx*2].b;
        bus4.in_op = tbl[idx*2].op; bus4.in_sat_en = tbl[idx*2].sat;
      end
      @(negedge clk);
      if (bus4.in_valid && !bus4.in_ready) saw_full = 1'b1;
      if (prev_stall) chk("bp/hold_sum", bus4.out_sum, held_sum);
      if (bus4.out_valid && bus4.out_ready) begin
        chk("bp/order_sum", bus4.out_sum, tbl[got*2].sum);
        chk("bp/order_ovf", bus4.out_ovf, tbl[got*2].ovf);
        got++;
      end
      in_hs      = bus4.in_valid && bus4.in_ready;
      prev_stall = bus4.out_valid && !bus4.out_ready;
      held_sum   = bus4.out_sum;
      @(posedge clk); #1;
      if (in_hs) idx++;
    end
    bus4.in_valid = 1'b0;
    chk("bp/in_ready_low", saw_full, 1);
    chk("bp/beats_out", got, 3);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp/no_duplicate", bus4.out_valid, 0);
    end

    // Randomised ops and stalls against the integer model
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    sticky_exp = '0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 300) begin
        bus4.in_valid  = ($urandom_range(0, 3) != 0);
        bus4.in_a      = 16'($urandom);
        bus4.in_b      = 16'($urandom);
        bus4.in_op     = 2'($urandom_range(0, 3));
        bus4.in_sat_en = 1'($urandom_range(0, 1));
        bus4.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
      end
      @(negedge clk);
      if (prev_stall) chk("rand/hold_sum", bus4.out_sum, held_sum);
      if (bus4.out_valid && bus4.out_ready) begin
        if (exp_sum_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rand/extra_beat: got sum %h, expected no beat", bus4.out_sum);
        end else begin
          ms = exp_sum_q.pop_front();
          mo = exp_ovf_q.pop_front();
          chk("rand/sum", bus4.out_sum, ms);
          chk("rand/ovf", bus4.out_ovf, mo[3:0]);
          chk("rand/error", bus4.out_error, |mo);
          sticky_exp |= mo[3:0];
        end
      end
      if (bus4.in_valid && bus4.in_ready) begin
        model(64'(bus4.in_a), 64'(bus4.in_b), bus4.in_op, bus4.in_sat_en, 4, 4, ms, mo);
        exp_sum_q.push_back(ms);
        exp_ovf_q.push_back(mo);
      end
      prev_stall = bus4.out_valid && !bus4.out_ready;
      held_sum   = bus4.out_sum;
      @(posedge clk); #1;
    end
    chk("rand/drained", exp_sum_q.size(), 0);
    chk("rand/sticky", sticky4, sticky_exp);

    // Reset with two beats in flight
    run_vec(tbl[0]);
    bus4.in_a = tbl[2].a; bus4.in_b = tbl[2].b; bus4.in_op = tbl[2].op;
    bus4.in_sat_en = tbl[2].sat; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.in_a = tbl[4].a; bus4.in_b = tbl[4].b; bus4.in_op = tbl[4].op;
    bus4.in_sat_en = tbl[4].sat; bus4.out_ready = 1'b0;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    chk("rst/pre_sticky", sticky4, sticky_exp | 4'b1010);
    chk("rst/pre_valid", bus4.out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    chk("rst/out_valid", bus4.out_valid, 0);
    chk("rst/sticky", sticky4, 0);
    chk("rst/out_sum", bus4.out_sum, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst/no_stale", bus4.out_valid, 0);
    end

    // Wider configuration
    run8("w8/hand", 64'h7F80_0000_0000_0001, 64'h01FF_0000_0000_0001, 2'b00, 1'b1,
         64'h7F80_0000_0000_0002, 8'b1100_0000);
    for (int i = 0; i < 16; i++) begin
      logic [63:0] a8, b8;
      logic [1:0]  op8;
      logic        sat8;
      a8 = {$urandom, $urandom};
      b8 = {$urandom, $urandom};
      op8 = 2'(i % 4);
      sat8 = 1'(i / 4 % 2);
      model(a8, b8, op8, sat8, 8, 8, ms, mo);
      run8("w8/rand", a8, b8, op8, sat8, ms, mo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
